// File: rtl/sublime_synth.sv
// Wishbone-controlled polyphonic wavetable synthesizer: two table oscillators per voice,
// round-robin voice engine, mono mix presented on both stereo outputs.
module sublime_synth #(
  parameter int unsigned NUM_VOICES     = 8,
  parameter int unsigned WAVETABLE_SIZE = 8192,
  parameter int unsigned WB_AW          = 32,
  parameter int unsigned WB_DW          = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic signed [31:0] left_sample,
  output logic signed [31:0] right_sample,
  input  logic [WB_AW-1:0]   wb_adr_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o
);

  localparam int unsigned WI = $clog2(WAVETABLE_SIZE);
  localparam int unsigned LV = $clog2(NUM_VOICES);
  localparam int unsigned VW = (LV > 0) ? LV : 1;
  localparam int unsigned AW = 32 + LV;

  // Per-voice register file and oscillator state
  logic [31:0] freq0  [NUM_VOICES];
  logic [31:0] freq1  [NUM_VOICES];
  logic [31:0] env    [NUM_VOICES];
  logic [6:0]  vel    [NUM_VOICES];
  logic        en0    [NUM_VOICES];
  logic        en1    [NUM_VOICES];
  logic [31:0] phase0 [NUM_VOICES];
  logic [31:0] phase1 [NUM_VOICES];
  logic        sync;

  logic [31:0] wt0 [WAVETABLE_SIZE];
  logic [31:0] wt1 [WAVETABLE_SIZE];

  // Bus decode
  logic          wb_req;
  logic          wb_wr;
  logic [1:0]    region;
  logic          voice_hit;
  logic          main_hit;
  logic [VW-1:0] voice_idx;
  logic [1:0]    reg_off;
  logic [WI-1:0] wt_idx;
  logic [31:0]   ctrl_cur;
  logic [31:0]   ctrl_new;
  logic [31:0]   reg_rd;

  assign wb_req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wb_wr     = wb_cyc_i & wb_stb_i & wb_we_i & wb_ack_o;
  assign region    = wb_adr_i[17:16];
  assign voice_hit = (region == 2'b00) && (wb_adr_i[15:4] < 12'(NUM_VOICES));
  assign main_hit  = (region == 2'b00) && (wb_adr_i[15:0] == 16'h0808);
  assign voice_idx = wb_adr_i[4 +: VW];
  assign reg_off   = wb_adr_i[3:2];
  assign wt_idx    = wb_adr_i[2 +: WI];
  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  assign ctrl_cur = {17'b0, vel[voice_idx], 6'b0, en1[voice_idx], en0[voice_idx]};
  assign ctrl_new = merge(ctrl_cur, wb_dat_i, wb_sel_i);

  always_comb begin
    reg_rd = '0;
    if (voice_hit) begin
      case (reg_off)
        2'd0: reg_rd = freq0[voice_idx];
        2'd1: reg_rd = freq1[voice_idx];
        2'd2: reg_rd = ctrl_cur;
        2'd3: reg_rd = env[voice_idx];
      endcase
    end else if (main_hit) begin
      reg_rd = {31'b0, sync};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq0[v] <= '0;
        freq1[v] <= '0;
        env[v]   <= '0;
        vel[v]   <= '0;
        en0[v]   <= 1'b0;
        en1[v]   <= 1'b0;
      end
      sync <= 1'b0;
    end else if (wb_wr) begin
      if (voice_hit) begin
        case (reg_off)
          2'd0: freq0[voice_idx] <= merge(freq0[voice_idx], wb_dat_i, wb_sel_i);
          2'd1: freq1[voice_idx] <= merge(freq1[voice_idx], wb_dat_i, wb_sel_i);
          2'd2: begin
            en0[voice_idx] <= ctrl_new[0];
            en1[voice_idx] <= ctrl_new[1];
            vel[voice_idx] <= ctrl_new[14:8];
          end
          2'd3: env[voice_idx] <= merge(env[voice_idx], wb_dat_i, wb_sel_i);
        endcase
      end
      if (main_hit && wb_sel_i[0]) sync <= wb_dat_i[0];
    end
  end

  // Ack is registered, so a held strobe is acknowledged every other cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= wb_req;
      if (wb_req) begin
        case (region)
          2'b00:   wb_dat_o <= reg_rd;
          2'b01:   wb_dat_o <= wt0[wt_idx];
          2'b10:   wb_dat_o <= wt1[wt_idx];
          default: wb_dat_o <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wb_wr && region == 2'b01) begin
      for (int b = 0; b < 4; b++) if (wb_sel_i[b]) wt0[wt_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
    if (wb_wr && region == 2'b10) begin
      for (int b = 0; b < 4; b++) if (wb_sel_i[b]) wt1[wt_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase0[v] <= '0;
        phase1[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase0[v] <= sync ? 32'h0 : phase0[v] + freq0[v];
        phase1[v] <= sync ? 32'h0 : phase1[v] + freq1[v];
      end
    end
  end

  // Voice engine: stage 1 table read, stage 2 scale, stage 3 accumulate
  logic [VW-1:0]      vc;
  logic [31:0]        t0, t1;
  logic               s1_en0, s1_en1, s1_last;
  logic [6:0]         s1_vel;
  logic signed [31:0] s2_voice;
  logic               s2_last;
  logic signed [AW-1:0] acc;

  logic signed [31:0]   s0_val, s1_val;
  logic signed [32:0]   pair_sum;
  logic signed [31:0]   pair;
  logic signed [39:0]   prod;
  logic signed [AW-1:0] acc_sum;

  // RAM read port output register; the enables gate it, so it needs no reset
  always_ff @(posedge clk) begin
    t0 <= wt0[phase0[vc][31 -: WI]];
    t1 <= wt1[phase1[vc][31 -: WI]];
  end

  assign s0_val   = s1_en0 ? $signed(t0) : 32'sd0;
  assign s1_val   = s1_en1 ? $signed(t1) : 32'sd0;
  assign pair_sum = {s0_val[31], s0_val} + {s1_val[31], s1_val};
  assign pair     = pair_sum[32:1];
  assign prod     = pair * $signed({1'b0, s1_vel});
  assign acc_sum  = acc + AW'(s2_voice);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vc          <= '0;
      s1_en0      <= 1'b0;
      s1_en1      <= 1'b0;
      s1_vel      <= '0;
      s1_last     <= 1'b0;
      s2_voice    <= '0;
      s2_last     <= 1'b0;
      acc         <= '0;
      left_sample <= '0;
    end else begin
      vc       <= (vc == VW'(NUM_VOICES - 1)) ? '0 : vc + 1'b1;
      s1_en0   <= en0[vc];
      s1_en1   <= en1[vc];
      s1_vel   <= vel[vc];
      s1_last  <= (vc == VW'(NUM_VOICES - 1));
      s2_voice <= prod[38:7];
      s2_last  <= s1_last;
      if (s2_last) begin
        left_sample <= acc_sum[LV +: 32];
        acc         <= '0;
      end else begin
        acc <= acc_sum;
      end
    end
  end

  assign right_sample = left_sample;

  logic unused_ok;
  assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_adr_i[WB_AW-1:18], pair_sum[0],
                       prod[39], prod[6:0], acc_sum};

endmodule

// File: tb/tb_sublime_synth.sv
// Directed bench for sublime_synth: bus access, table load, and mixer arithmetic
// checked with SYNC holding every oscillator on table index 0.
module tb_sublime_synth;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] left_sample, right_sample;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;

  int errors = 0;
  int checks = 0;

  sublime_synth dut (
    .clk(clk), .rst(rst), .left_sample(left_sample), .right_sample(right_sample),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called and returns at posedge+1; waits = clocks from strobe to ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output int waits);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    waits = 0;
    do begin
      @(posedge clk); #1;
      waits++;
    end while (!wb_ack_o && waits < 16);
    if (!wb_ack_o) begin
      checks++; errors++;
      $display("FAIL ack_timeout: adr %h got no ack within 16 clocks", adr);
    end
    rdat = wb_dat_o;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    int w;
    wb_xfer(1'b1, adr, dat, sel, d, w);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] dat);
    int w;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, dat, w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] tri_val(input int i);
    int k, q;
    logic [31:0] mag;
    k = i % 2048;
    q = i / 2048;
    mag = (q == 0 || q == 2) ? 32'(k * 1048576) : 32'((2047 - k) * 1048576);
    return (q < 2) ? mag : -mag;
  endfunction

  typedef struct {
    logic [31:0] ctrl;
    int          nv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd, l1, l2, prev;
    logic [3:0]  ack_pat;
    int w, changes, last_chg, bad_gap, lr_bad;

    vecs[0]  = '{32'h3f03, 8, 32'h40000000, 32'h40000000, 32'h1F800000};
    vecs[1]  = '{32'h3f01, 8, 32'h40000000, 32'h40000000, 32'h0FC00000};
    vecs[2]  = '{32'h3f02, 8, 32'h40000000, 32'hC0000000, 32'hF0400000};
    vecs[3]  = '{32'h7f03, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0FDFFFFF};
    vecs[4]  = '{32'h7f03, 8, 32'h80000000, 32'h80000000, 32'h81000000};
    vecs[5]  = '{32'h0003, 8, 32'h40000000, 32'h40000000, 32'h00000000};
    vecs[6]  = '{32'h0103, 8, 32'h00000100, 32'h00000000, 32'h00000001};
    vecs[7]  = '{32'h0103, 8, 32'hFFFFFF00, 32'h00000000, 32'hFFFFFFFF};
    vecs[8]  = '{32'h0103, 1, 32'hFFFFFF00, 32'h00000000, 32'hFFFFFFFF};
    vecs[9]  = '{32'h3f00, 8, 32'h40000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{32'h4003, 4, 32'h10000000, 32'h30000000, 32'h08000000};
    vecs[11] = '{32'h7f01, 2, 32'h00001000, 32'h7FFFFFFF, 32'h000001FC};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    check("reset_left", left_sample, 32'h0);
    check("reset_right", right_sample, 32'h0);
    check("reset_ack", {31'b0, wb_ack_o}, 32'h0);
    check("reset_dat", wb_dat_o, 32'h0);
    wb_rd(32'h08, rd);       check("reset_ctrl0", rd, 32'h0);
    wb_rd(32'h808, rd);      check("reset_main", rd, 32'h0);
    check("err_rty", {30'b0, wb_err_o, wb_rty_o}, 32'h0);

    wb_wr(32'h28, 32'h3f03, 4'hF);
    wb_rd(32'h28, rd);       check("ctrl2_rw", rd, 32'h3f03);
    wb_wr(32'h38, 32'hFFFFFFFF, 4'hF);
    wb_rd(32'h38, rd);       check("ctrl3_mask", rd, 32'h00007F03);
    wb_wr(32'h2C, 32'hFFFFFFFF, 4'b0001);
    wb_rd(32'h2C, rd);       check("env2_sel", rd, 32'h000000FF);
    wb_wr(32'h04, 32'h12345678, 4'hF);
    wb_wr(32'h04, 32'hAABBCCDD, 4'b0110);
    wb_rd(32'h04, rd);       check("freq1_sel", rd, 32'h12BBCC78);
    wb_wr(32'h04, 32'h0, 4'hF);
    wb_wr(32'h38, 32'h0, 4'hF);

    // Unmapped space still acks after one clock and reads zero
    wb_xfer(1'b1, 32'h30000, 32'hDEADBEEF, 4'hF, rd, w);
    check("unmapped_wr_lat", 32'(w), 32'd1);
    wb_xfer(1'b0, 32'h30000, 32'h0, 4'hF, rd, w);
    check("unmapped_rd_lat", 32'(w), 32'd1);
    check("unmapped_rd", rd, 32'h0);

    // Held strobe: ack pulses every other clock
    wb_adr_i = 32'h28; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ack_pat[i] = wb_ack_o;
      if (i == 2) check("b2b_data", wb_dat_o, 32'h3f03);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("b2b_ack_pattern", {28'b0, ack_pat}, 32'h5);
    idle(1);
    check("ack_single", {31'b0, wb_ack_o}, 32'h0);

    wb_wr(32'h10014, 32'h11223344, 4'hF);
    wb_wr(32'h10014, 32'hAABBCCDD, 4'b1010);
    wb_rd(32'h10014, rd);    check("wt0_sel", rd, 32'hAA22CC44);

    for (int i = 0; i < 8192; i++) begin
      wb_wr(32'h10000 + 32'(4 * i), tri_val(i), 4'hF);
      wb_wr(32'h20000 + 32'(4 * i), tri_val(i), 4'hF);
    end
    wb_rd(32'h10000 + 4 * 100, rd);  check("wt0_100", rd, 32'h06400000);
    wb_rd(32'h20000 + 4 * 100, rd);  check("wt1_100", rd, 32'h06400000);
    wb_rd(32'h10000 + 4 * 3000, rd); check("wt0_3000", rd, 32'h44700000);
    wb_rd(32'h20000 + 4 * 5000, rd); check("wt1_5000", rd, 32'hC7800000);

    wb_wr(32'h808, 32'h1, 4'hF);
    wb_rd(32'h808, rd);      check("sync_set", rd, 32'h1);

    // With SYNC held every voice reads index 0, so table entry 0 sets the mix
    for (int n = 0; n < 12; n++) begin
      for (int v = 0; v < 8; v++) wb_wr(32'(v * 16 + 8), (v < vecs[n].nv) ? vecs[n].ctrl : 0, 4'hF);
      wb_wr(32'h10000, vecs[n].a, 4'hF);
      wb_wr(32'h20000, vecs[n].b, 4'hF);
      idle(24);
      check($sformatf("mix_left[%0d]", n), left_sample, vecs[n].exp);
      check($sformatf("mix_right[%0d]", n), right_sample, vecs[n].exp);
    end
    wb_wr(32'h10000, 32'h0, 4'hF);
    wb_wr(32'h20000, 32'h0, 4'hF);

    for (int v = 0; v < 8; v++) begin
      wb_wr(32'(v * 16 + 0), (v < 3) ? 32'd37796 : 32'd0, 4'hF);
      wb_wr(32'(v * 16 + 4), (v < 3) ? 32'd37796 : 32'd0, 4'hF);
      wb_wr(32'(v * 16 + 8), (v < 3) ? 32'h3f03 : 32'h0, 4'hF);
    end
    idle(24);
    check("sync_hold_zero", left_sample, 32'h0);

    wb_wr(32'h808, 32'h0, 4'hF);
    idle(2000);
    l1 = left_sample;
    check("tone_lr", right_sample, l1);
    check("tone_range", {31'b0, $signed(l1) > 0 && $signed(l1) <= 396361728}, 32'h1);
    idle(3000);
    l2 = left_sample;
    check("tone_rising", {31'b0, $signed(l2) > $signed(l1)}, 32'h1);

    // Output only updates on round boundaries, NUM_VOICES clocks apart
    prev = left_sample; changes = 0; last_chg = -1; bad_gap = 0; lr_bad = 0;
    for (int i = 0; i < 64; i++) begin
      idle(1);
      if (left_sample !== right_sample) lr_bad++;
      if (left_sample !== prev) begin
        if (last_chg >= 0 && ((i - last_chg) % 8) != 0) bad_gap++;
        last_chg = i;
        changes++;
        prev = left_sample;
      end
    end
    check("hold_gap", 32'(bad_gap), 32'h0);
    check("hold_lr", 32'(lr_bad), 32'h0);
    check("hold_changes", {31'b0, changes >= 1 && changes <= 8}, 32'h1);

    for (int v = 0; v < 3; v++) wb_wr(32'(v * 16 + 8), 32'h3f00, 4'hF);
    idle(19);
    check("gate_off_zero", left_sample, 32'h0);
    check("err_rty_end", {30'b0, wb_err_o, wb_rty_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
